// File: rtl/sram_controller.sv
// Single-outstanding-request responder for an external asynchronous 16-bit SRAM.
// Every SRAM pin control is registered; write data is driven only while a write is in flight.
module sram_controller #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_dq,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_ub_n,
  output logic              mem_lb_n
);

  typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              ready_nxt, ce_nxt, oe_nxt, we_nxt;
  logic              dq_oe, dq_oe_nxt;
  logic              byte_en_n;
  logic              load_wr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic [DATA_W-1:0] dq_wr;

  assign mem_dq   = dq_oe ? dq_wr : {DATA_W{1'bz}};
  assign mem_ub_n = byte_en_n;
  assign mem_lb_n = byte_en_n;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_nxt = ready;
    ce_nxt    = mem_ce_n;
    oe_nxt    = mem_oe_n;
    we_nxt    = mem_we_n;
    dq_oe_nxt = dq_oe;
    addr_nxt  = mem_addr;
    dout_nxt  = data_out;
    load_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt  = addr;
          ready_nxt = 1'b0;
          ce_nxt    = 1'b0;
          if (rw) begin
            state_nxt = RD_ACC;
            oe_nxt    = 1'b0;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = WR_SETUP;
            dq_oe_nxt = 1'b1;
            load_wr   = 1'b1;
          end
        end
      end
      RD_ACC: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          dout_nxt  = mem_dq;
          oe_nxt    = 1'b1;
          ce_nxt    = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_SETUP: begin
        we_nxt    = 1'b0;
        cnt_nxt   = CNT_INIT;
        state_nxt = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt != 3'd0) begin
          cnt_nxt = cnt - 3'd1;
        end else begin
          we_nxt    = 1'b1;
          state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: begin
        // Releasing dq here lets a read start on the very next edge without bus contention.
        ce_nxt    = 1'b1;
        dq_oe_nxt = 1'b0;
        ready_nxt = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      ready     <= 1'b1;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      dq_oe     <= 1'b0;
      byte_en_n <= 1'b1;
      mem_addr  <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready     <= ready_nxt;
      mem_ce_n  <= ce_nxt;
      mem_oe_n  <= oe_nxt;
      mem_we_n  <= we_nxt;
      dq_oe     <= dq_oe_nxt;
      byte_en_n <= 1'b0;
      mem_addr  <= addr_nxt;
      data_out  <= dout_nxt;
    end
  end

  // Write data is only visible on the pins while dq_oe is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_wr) dq_wr <= data_in;
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an asynchronous SRAM model on the pins plus a transaction-level
// reference that predicts every pin and handshake from request timing alone.
module tb_sram_controller;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          ready;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_dq;
  logic          mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;

  sram_controller #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ready(ready), .mem_addr(mem_addr),
    .mem_dq(mem_dq), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: drives dq while selected for read, stores on every edge with WE low.
  logic [DW-1:0] sram [0:65535];
  assign mem_dq = (!mem_ce_n && !mem_oe_n && mem_we_n) ? sram[mem_addr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (!mem_ce_n && !mem_we_n) sram[mem_addr] <= mem_dq;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s timeout waiting for ready at %0t", nm, $time);
  endtask

  // Reference: a request occupies the bus for a fixed number of cycles; strobes follow
  // from the cycle offset k since acceptance.
  logic          m_busy = 1'b0;
  logic          m_rw   = 1'b0;
  int            m_k    = 0;
  int            m_len  = 0;
  logic [AW-1:0] m_a    = '0;
  logic [DW-1:0] m_d    = '0;
  logic [DW-1:0] m_dout = '0;
  logic          m_ub   = 1'b1;
  logic          chk_en = 1'b0;
  logic [DW-1:0] shadow [0:65535];

  always @(posedge clk) begin
    int nk;
    nk = m_k + 1;
    if (m_busy && !m_rw && m_k >= 1 && m_k <= W) shadow[m_a] <= m_d;
    chk_en <= 1'b1;
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_a    <= '0;
      m_dout <= '0;
      m_ub   <= 1'b1;
    end else begin
      m_ub <= 1'b0;
      if (m_busy) begin
        m_k <= nk;
        if (nk == m_len) begin
          m_busy <= 1'b0;
          if (m_rw) m_dout <= shadow[m_a];
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_rw   <= rw;
        m_a    <= addr;
        m_d    <= data_in;
        m_len  <= rw ? W : W + 2;
      end
    end
  end

  int   we_lo = 0, oe_lo = 0, rdy_lo = 0, acc = 0;
  logic prev_ce = 1'b1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",    32'(ready),    32'(!m_busy));
      check("ce_n",     32'(mem_ce_n), 32'(!m_busy));
      check("oe_n",     32'(mem_oe_n), 32'(!(m_busy && m_rw)));
      check("we_n",     32'(mem_we_n), 32'(!(m_busy && !m_rw && m_k >= 1 && m_k <= W)));
      check("ub_n",     32'(mem_ub_n), 32'(m_ub));
      check("lb_n",     32'(mem_lb_n), 32'(m_ub));
      check("mem_addr", 32'(mem_addr), 32'(m_a));
      check("data_out", 32'(data_out), 32'(m_dout));
      if (m_busy && !m_rw) check("mem_dq_wr", 32'(mem_dq), 32'(m_d));
      if (!mem_we_n) we_lo++;
      if (!mem_oe_n) oe_lo++;
      if (!ready) rdy_lo++;
      if (!mem_ce_n && prev_ce) acc++;
      prev_ce = mem_ce_n;
    end
  end

  task automatic do_req(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < 50 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ready) timeout_fail("req_wait");
    start = 1'b1; rw = r; addr = a; data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 50 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ready) timeout_fail(nm);
  endtask

  logic [AW-1:0] pool [8];
  int s_we, s_oe, s_rdy, s_acc;

  initial begin
    pool[0] = 16'h0000; pool[1] = 16'h0003; pool[2] = 16'h00A5; pool[3] = 16'h1234;
    pool[4] = 16'h7FFF; pool[5] = 16'h8000; pool[6] = 16'hFFFE; pool[7] = 16'hFFFF;

    // Reset held 3 clocks with start asserted: nothing may strobe.
    start = 1'b1; rw = 1'b1; addr = 16'h0001;
    s_acc = acc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    32'(ready),    32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_ce_n",     32'(mem_ce_n), 32'd1);
    check("rst_oe_n",     32'(mem_oe_n), 32'd1);
    check("rst_we_n",     32'(mem_we_n), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_no_access", 32'(acc - s_acc), 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ub_after_rst", 32'(mem_ub_n), 32'd0);

    // Write 0x1234 @ 0x00A5.
    s_we = we_lo; s_rdy = rdy_lo;
    do_req(1'b0, 16'h00A5, 16'h1234);
    wait_idle("write1");
    check("wr_we_low_cycles",    32'(we_lo - s_we),   32'd2);
    check("wr_ready_low_cycles", 32'(rdy_lo - s_rdy), 32'd4);
    check("wr_sram_content",     32'(sram[16'h00A5]), 32'h1234);

    // Read it back.
    s_oe = oe_lo; s_rdy = rdy_lo;
    do_req(1'b1, 16'h00A5, 16'h0000);
    wait_idle("read1");
    check("rd_oe_low_cycles",    32'(oe_lo - s_oe),   32'd2);
    check("rd_ready_low_cycles", 32'(rdy_lo - s_rdy), 32'd2);
    check("rd_data",             32'(data_out),       32'h1234);

    // Start pulses during a write are ignored.
    s_acc = acc;
    do_req(1'b0, 16'h0002, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; rw = 1'b1; addr = 16'h0001;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle("busy");
    check("busy_one_access", 32'(acc - s_acc), 32'd1);
    check("busy_sram",       32'(sram[16'h0002]), 32'h5555);

    // Back-to-back write then read at the all-ones address.
    do_req(1'b0, 16'hFFFF, 16'hBEEF);
    do_req(1'b1, 16'hFFFF, 16'h0000);
    wait_idle("b2b");
    check("b2b_data", 32'(data_out), 32'hBEEF);

    // Reset while WE is low.
    do_req(1'b0, 16'h0010, 16'hAAAA);
    for (int i = 0; i < 10 && mem_we_n; i++) begin
      @(posedge clk);
      #1;
    end
    check("we_reached_low", 32'(mem_we_n), 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_we_n",     32'(mem_we_n), 32'd1);
    check("midrst_ce_n",     32'(mem_ce_n), 32'd1);
    check("midrst_ready",    32'(ready),    32'd1);
    check("midrst_data_out", 32'(data_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the random address pool, then random traffic with occasional resets.
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, pool[i], 16'($urandom));
      wait_idle("prefill");
    end
    for (int c = 0; c < 1500; c++) begin
      start   = ($urandom_range(0, 2) == 0);
      rw      = 1'($urandom_range(0, 1));
      addr    = pool[$urandom_range(0, 7)];
      data_in = 16'($urandom);
      reset_n = ($urandom_range(0, 199) != 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset_n = 1'b1;
    wait_idle("random_end");
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
